// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, types and helpers for the FIR accelerator
// result path. New code uses these in place of the old header macros.
//   DATA_WIDTH          - accelerator result word width
//   NUM_REGS            - number of accelerator coefficient/tap registers
//   fir_word_t          - one accelerator result word
//   FIFO_DEPTH_DEFAULT  - default depth of the result FIFO
//   COUNT_WIDTH         - occupancy counter width for the default depth
//   fir_count_width()   - occupancy counter width for any power-of-2 depth
package fir_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int NUM_REGS   = 8;

  typedef logic [DATA_WIDTH-1:0] fir_word_t;

  // The counter must represent 0..depth inclusive, hence one extra bit
  // beyond the pointer width.
  function automatic int fir_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int FIFO_DEPTH_DEFAULT = 8;
  localparam int COUNT_WIDTH        = fir_count_width(FIFO_DEPTH_DEFAULT);

endpackage

// File: rtl/fir_sync_fifo.sv
// fir_sync_fifo: synchronous first-word-fall-through FIFO.
//   clk      in   clock
//   rstN     in   asynchronous active-low reset (pointers/count only)
//   push_i   in   write wdata_i this cycle (ignored when full and not popping)
//   pop_i    in   retire the head word this cycle (ignored when empty)
//   flush_i  in   synchronous clear, overrides push_i and pop_i
//   wdata_i  in   word to write
//   rdata_o  out  head word, forced to 0 while empty
//   count_o  out  occupancy 0..DEPTH
//   full_o   out  count_o == DEPTH
//   empty_o  out  count_o == 0
module fir_sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);
  import fir_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = fir_count_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

  // Guards make the FIFO self-protecting even if a caller pushes into a
  // full FIFO without a pop, or pops an empty one.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the empty mask below keeps rdata_o X-free.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/fir_result_reader.sv
// fir_result_reader: captures accelerator result words into a FWFT FIFO
// and serves them over a valid/ready read port; counts words lost to a
// full FIFO.
//   clk             in   clock
//   rstN            in   asynchronous active-low reset
//   resultIn        in   accelerator result word
//   resultInValid   in   single-cycle qualifier, no backpressure upstream
//   flush           in   synchronous FIFO clear (overflow state untouched)
//   clrOverflow     in   synchronous clear of overflowCount/overflowSticky
//   dataOut         out  head-of-FIFO word (0 while empty)
//   dataOutValid    out  FIFO non-empty
//   dataOutReady    in   consumer accepts dataOut this cycle
//   count           out  occupancy 0..DEPTH
//   full            out  count == DEPTH
//   empty           out  count == 0
//   overflowCount   out  saturating count of dropped words
//   overflowSticky  out  set on any drop until cleared
module fir_result_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int OVF_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic [DATA_WIDTH-1:0]   resultIn,
  input  logic                    resultInValid,
  input  logic                    flush,
  input  logic                    clrOverflow,
  output logic [DATA_WIDTH-1:0]   dataOut,
  output logic                    dataOutValid,
  input  logic                    dataOutReady,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic [OVF_WIDTH-1:0]    overflowCount,
  output logic                    overflowSticky
);
  import fir_pkg::*;

  logic                 push, pop, drop;
  logic [OVF_WIDTH-1:0] ovf_count_q, ovf_count_d;
  logic                 ovf_sticky_q, ovf_sticky_d;

  assign dataOutValid = !empty;
  assign pop  = dataOutValid && dataOutReady;
  assign push = resultInValid && (!full || pop);
  // A word discarded by flush is intentional, not a loss.
  assign drop = resultInValid && full && !pop && !flush;

  fir_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstN    (rstN),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (resultIn),
    .rdata_o (dataOut),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // A drop coincident with a clear survives as the first counted drop.
  always_comb begin
    ovf_count_d  = ovf_count_q;
    ovf_sticky_d = ovf_sticky_q;
    if (clrOverflow) begin
      ovf_count_d  = drop ? OVF_WIDTH'(1) : '0;
      ovf_sticky_d = drop;
    end else if (drop) begin
      ovf_sticky_d = 1'b1;
      if (ovf_count_q != '1) ovf_count_d = ovf_count_q + OVF_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ovf_count_q  <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      ovf_count_q  <= ovf_count_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign overflowCount  = ovf_count_q;
  assign overflowSticky = ovf_sticky_q;

endmodule

// File: tb/tb_fir_result_reader.sv
module tb_fir_result_reader;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int OVW   = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int OVMAX = (1 << OVW) - 1;

  logic          clk = 1'b0;
  logic          rstN = 1'b1;
  logic [DW-1:0] resultIn = '0;
  logic          resultInValid = 1'b0;
  logic          flush = 1'b0;
  logic          clrOverflow = 1'b0;
  logic [DW-1:0] dataOut;
  logic          dataOutValid;
  logic          dataOutReady = 1'b0;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic [OVW-1:0] overflowCount;
  logic          overflowSticky;

  fir_result_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .OVF_WIDTH(OVW)) dut (
    .clk            (clk),
    .rstN           (rstN),
    .resultIn       (resultIn),
    .resultInValid  (resultInValid),
    .flush          (flush),
    .clrOverflow    (clrOverflow),
    .dataOut        (dataOut),
    .dataOutValid   (dataOutValid),
    .dataOutReady   (dataOutReady),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .overflowCount  (overflowCount),
    .overflowSticky (overflowSticky)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of accepted words plus drop bookkeeping.
  logic [DW-1:0] q[$];
  int            m_ovf = 0;
  bit            m_sticky = 1'b0;
  int            m_drops_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("count_bound", 32'(int'(count) <= DEPTH), 32'd1);
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("valid", 32'(dataOutValid), 32'(n != 0));
    chk("dataOut", 32'(dataOut), (n != 0) ? 32'(q[0]) : 32'd0);
    chk("ovfCount", 32'(overflowCount), 32'(m_ovf));
    chk("sticky", 32'(overflowSticky), 32'(m_sticky));
  endtask

  // Drive one cycle, advance the model with the rules of the read port,
  // then compare everything 1 time unit after the edge.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit rdy,
                      input bit fl = 1'b0, input bit clr = 1'b0);
    bit m_full, m_pop, m_drop;
    resultInValid = v;
    resultIn      = d;
    dataOutReady  = rdy;
    flush         = fl;
    clrOverflow   = clr;
    @(posedge clk);
    m_full = (q.size() == DEPTH);
    m_pop  = (q.size() > 0) && rdy;
    m_drop = 1'b0;
    if (fl) begin
      q.delete();
    end else begin
      if (m_pop) void'(q.pop_front());
      if (v) begin
        if (!m_full || m_pop) q.push_back(d);
        else m_drop = 1'b1;
      end
    end
    if (m_drop) m_drops_total++;
    if (clr) begin
      m_ovf    = m_drop ? 1 : 0;
      m_sticky = m_drop;
    end else if (m_drop) begin
      m_sticky = 1'b1;
      if (m_ovf < OVMAX) m_ovf++;
    end
    #1;
    compare_all();
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf    = 0;
    m_sticky = 1'b0;
  endtask

  initial begin
    int drops_before;
    // Reset assertion checked immediately (asynchronous).
    #2 rstN = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b1;

    // Three pushes with ready low.
    step(1, 16'h0011, 0);
    step(1, 16'h0022, 0);
    step(1, 16'h0033, 0);
    chk("tp1_count", 32'(count), 32'd3);
    chk("tp1_head", 32'(dataOut), 32'h0011);
    chk("tp1_pop0", 32'(dataOut), 32'h0011);
    step(0, '0, 1);
    chk("tp1_pop1", 32'(dataOut), 32'h0022);
    step(0, '0, 1);
    chk("tp1_pop2", 32'(dataOut), 32'h0033);
    step(0, '0, 1);
    chk("tp1_empty", 32'(empty), 32'd1);

    // Fill, then overflow with ready low.
    for (int i = 0; i < DEPTH; i++) step(1, DW'(16'h0100 + i), 0);
    step(1, 16'h0AAA, 0);
    chk("drop_ovf", 32'(overflowCount), 32'd1);
    chk("drop_sticky", 32'(overflowSticky), 32'd1);
    chk("drop_head", 32'(dataOut), 32'h0100);

    // Full with simultaneous pop: accepted, count holds.
    step(1, 16'h0BBB, 1);
    chk("fullpop_count", 32'(count), 32'd8);
    chk("fullpop_ovf", 32'(overflowCount), 32'd1);
    while (count > 1) step(0, '0, 1);
    chk("wrap_last", 32'(dataOut), 32'h0BBB);
    step(0, '0, 1);

    // Saturation and clear.
    for (int i = 0; i < DEPTH; i++) step(1, DW'($urandom), 0);
    for (int i = 0; i < 300; i++) step(1, DW'($urandom), 0);
    chk("sat_ovf", 32'(overflowCount), 32'd255);
    step(1, 16'h1234, 0, 0, 1);
    chk("clr_drop_ovf", 32'(overflowCount), 32'd1);
    chk("clr_drop_sticky", 32'(overflowSticky), 32'd1);
    step(0, '0, 0, 0, 1);
    chk("clr_ovf", 32'(overflowCount), 32'd0);
    chk("clr_sticky", 32'(overflowSticky), 32'd0);

    // Flush with coincident push and ready.
    step(0, '0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, DW'(16'h0200 + i), 0);
    step(1, 16'h0CCC, 1, 1, 0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(dataOutValid), 32'd0);
    chk("flush_nodrop", 32'(overflowCount), 32'd0);

    // Reset mid-stream.
    step(1, 16'h0DDD, 0);
    resultInValid = 1'b0;
    #1 rstN = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_dataOut", 32'(dataOut), 32'd0);
    @(posedge clk);
    @(negedge clk) rstN = 1'b1;
    step(1, 16'h0EEE, 0);
    chk("post_rst_head", 32'(dataOut), 32'h0EEE);
    step(0, '0, 0, 1, 0);

    // Random stress against the queue model.
    drops_before = m_drops_total;
    for (int c = 0; c < 10000; c++) begin
      step($urandom_range(0, 99) < 70, DW'($urandom), $urandom_range(0, 99) < 50,
           $urandom_range(0, 199) == 0, $urandom_range(0, 299) == 0);
    end
    $display("stress: model drops %0d", m_drops_total - drops_before);

    resultInValid = 1'b0;
    dataOutReady  = 1'b0;
    flush         = 1'b0;
    clrOverflow   = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
